// File: rtl/twos_comp_seq_divider.sv
// ---------------------------------------------------------------------------
// twos_comp_seq_divider
//
// Sequential signed two's-complement divider. The divider works on operand
// magnitudes and uses restoring shift-subtract, so it produces one quotient
// bit per clock. The signs are applied to the magnitudes in a final fix-up
// cycle. A start/busy/done handshake drives it. The latency is always
// WIDTH+1 clocks from the accepting edge, whatever the operand values.
//
// Parameters
//   WIDTH        operand/result width in bits (two's complement, >= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; abandons any division
//   start        request, sampled only while idle
//   x            signed dividend, captured on the accepting edge
//   y            signed divisor, captured on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse when results are updated
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, sign follows the dividend
//   div_by_zero  set with done when y == 0
//   overflow     set with done for -2^(WIDTH-1) / -1
// ---------------------------------------------------------------------------
module twos_comp_seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] y,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic                    div_by_zero,
   output logic                    overflow
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   ONE_W1  = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CW-1:0]    CNT_START = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Magnitude as a WIDTH-bit unsigned value. -2^(WIDTH-1) maps onto
   // 2^(WIDTH-1), which is representable unsigned, so no saturation occurs.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + ONE_W) : v;
   endfunction

   // Re-apply a sign to a magnitude. The result wraps modulo 2^WIDTH, which
   // gives the defined -2^(WIDTH-1) quotient for the overflow case.
   function automatic logic [WIDTH-1:0] apply_sign(input logic             neg,
                                                   input logic [WIDTH-1:0] m);
      return neg ? (~m + ONE_W) : m;
   endfunction

   state_t            state;
   logic [CW-1:0]     cnt;

   // Operand bookkeeping captured on the accepting edge
   logic [WIDTH-1:0]  dvd_sh;      // dividend magnitude, shifted out MSB first
   logic [WIDTH-1:0]  dsr_mag;     // divisor magnitude
   logic [WIDTH-1:0]  x_cap;       // raw dividend, forced remainder on /0
   logic              sign_q;
   logic              sign_r;
   logic              zero_div;
   logic              ovf_case;

   // Iteration state
   logic [WIDTH:0]    part_rem;    // partial remainder (one guard bit)
   logic [WIDTH-1:0]  q_mag;       // quotient magnitude, built LSB-in

   // One restoring step
   logic [WIDTH:0]    shifted;
   logic [WIDTH:0]    trial;
   logic              trial_ok;

   always_comb begin
      shifted  = '0;
      trial    = '0;
      trial_ok = 1'b0;
      shifted  = {part_rem[WIDTH-1:0], dvd_sh[WIDTH-1]};
      // Subtract as add of the inverted (zero-extended) divisor plus one
      trial    = shifted + {1'b1, ~dsr_mag} + ONE_W1;
      trial_ok = ~trial[WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         dvd_sh      <= '0;
         dsr_mag     <= '0;
         x_cap       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero_div    <= 1'b0;
         ovf_case    <= 1'b0;
         part_rem    <= '0;
         q_mag       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_DIV;
                  busy     <= 1'b1;
                  cnt      <= CNT_START;
                  dvd_sh   <= magnitude(x);
                  dsr_mag  <= magnitude(y);
                  x_cap    <= x;
                  sign_q   <= x[WIDTH-1] ^ y[WIDTH-1];
                  sign_r   <= x[WIDTH-1];
                  zero_div <= (y == '0);
                  ovf_case <= (x == MOST_NEG) && (y == ALL_ONES);
                  part_rem <= '0;
                  q_mag    <= '0;
               end
            end

            S_DIV: begin
               dvd_sh   <= {dvd_sh[WIDTH-2:0], 1'b0};
               part_rem <= trial_ok ? trial : shifted;
               q_mag    <= {q_mag[WIDTH-2:0], trial_ok};
               if (cnt == '0) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_FIX: begin
               state       <= S_IDLE;
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= zero_div;
               overflow    <= ovf_case & ~zero_div;
               if (zero_div) begin
                  quotient  <= ALL_ONES;
                  remainder <= x_cap;
               end else begin
                  quotient  <= apply_sign(sign_q, q_mag);
                  remainder <= apply_sign(sign_r, part_rem[WIDTH-1:0]);
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_twos_comp_seq_divider.sv
module tb_twos_comp_seq_divider;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
   logic         overflow;

   int n_checks;
   int n_errors;

   twos_comp_seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .x           (x),
      .y           (y),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Edge then a small settle delay, so sampling is away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full division: accept, watch busy/done over the whole latency, check results
   task automatic run_div(input string tag, input logic [W-1:0] xi, input logic [W-1:0] yi,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eov);
      int busy_cnt;
      int done_cnt;
      busy_cnt = 0;
      done_cnt = 0;
      x = xi;
      y = yi;
      start = 1'b1;
      tick();                       // E0
      start = 1'b0;
      for (int i = 1; i <= W + 1; i++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         tick();                    // E1 .. E(W+1)
      end
      check({tag, " done@lat"}, done, 1'b1);
      check({tag, " busy@done"}, busy, 1'b0);
      check({tag, " busy cycles"}, busy_cnt, W + 1);
      check({tag, " early done"}, done_cnt, 0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, edz);
      check({tag, " overflow"}, overflow, eov);
      tick();
      check({tag, " done pulse"}, done, 1'b0);
   endtask

   initial begin
      int seen_done;
      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      y     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst quotient", quotient, 4'b0000);
      check("rst remainder", remainder, 4'b0000);
      check("rst flags", {div_by_zero, overflow}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_div("7/2",   4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0);
      run_div("-7/2",  4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0);
      run_div("7/-2",  4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0);
      run_div("-7/-2", 4'b1001, 4'b1110, 4'b0011, 4'b1111, 1'b0, 1'b0);
      run_div("-8/-1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1);
      run_div("5/0",   4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0);
      run_div("-8/1",  4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0);
      run_div("3/5",   4'b0011, 4'b0101, 4'b0000, 4'b0011, 1'b0, 1'b0);

      // Start pulse while busy must be ignored
      x = 4'd7; y = 4'd2; start = 1'b1;
      tick();                        // E0
      start = 1'b0;
      tick(); tick();                // E1, E2
      x = 4'd6; y = 4'd3; start = 1'b1;
      tick();                        // E3
      start = 1'b0;
      tick(); tick();                // E4, E5
      check("ignore done", done, 1'b1);
      check("ignore quotient", quotient, 4'b0011);
      check("ignore remainder", remainder, 4'b0001);
      tick();
      check("ignore no restart", busy, 1'b0);

      // Back-to-back: start held through the done cycle
      x = 4'd7; y = 4'd2; start = 1'b1;
      tick();                        // E0
      x = 4'd6; y = 4'd3;
      for (int i = 1; i <= W + 1; i++) tick();   // E5
      check("b2b first done", done, 1'b1);
      check("b2b first quotient", quotient, 4'b0011);
      check("b2b first remainder", remainder, 4'b0001);
      tick();                        // E6 accepts 6/3
      start = 1'b0;
      check("b2b accept busy", busy, 1'b1);
      check("b2b accept done", done, 1'b0);
      check("b2b hold quotient", quotient, 4'b0011);
      for (int i = 1; i <= W + 1; i++) tick();   // E11
      check("b2b second done", done, 1'b1);
      check("b2b second quotient", quotient, 4'b0010);
      check("b2b second remainder", remainder, 4'b0000);
      tick();

      // Asynchronous reset mid-division
      x = 4'd7; y = 4'd2; start = 1'b1;
      tick();                        // E0
      start = 1'b0;
      tick(); tick(); tick();        // E3
      #2;
      rst = 1'b1;
      #1;
      check("arst busy", busy, 1'b0);
      check("arst done", done, 1'b0);
      check("arst quotient", quotient, 4'b0000);
      check("arst remainder", remainder, 4'b0000);
      check("arst flags", {div_by_zero, overflow}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (done || busy) seen_done++;
      end
      check("arst no done", seen_done, 0);

      @(negedge clk);
      run_div("5/-3", 4'b0101, 4'b1101, 4'b1111, 4'b0010, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
